// File: rtl/multi_digit_counter.sv
// rtl/multi_digit_counter.sv - prescaled N-digit BCD/hex up/down counter with seven-segment decode
module multi_digit_counter #(
  parameter int N_DIGITS       = 4,
  parameter int TICK_DIV       = 50_000_000,
  parameter int RADIX_BCD      = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_step,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_load_val,
  output logic [4*N_DIGITS-1:0] o_count,
  output logic                  o_tick,
  output logic                  o_wrap,
  output logic [7*N_DIGITS-1:0] o_seg
);

  localparam int CW = 4 * N_DIGITS;
  localparam int SW = 7 * N_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] DMAX    = (RADIX_BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_ZERO = 7'h3F ^ SEG_XOR;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          expire, step;
  logic          carry;
  logic [3:0]    dig;

  assign expire = i_en && (presc_q == PW'(TICK_DIV - 1));
  assign step   = expire || i_step;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = expire;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    if (i_load) begin
      presc_d = '0;
    end else if (i_en) begin
      presc_d = expire ? '0 : presc_q + 1'b1;
    end
    if (i_load) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        dig = i_load_val[4*k +: 4];
        count_d[4*k +: 4] = (RADIX_BCD != 0 && dig > 4'd9) ? 4'd9 : dig;
      end
    end else if (step) begin
      // Ripple carry (up) or borrow (down) from digit 0; surviving carry means wrap.
      for (int k = 0; k < N_DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (i_up) begin
            carry = (dig == DMAX);
            count_d[4*k +: 4] = carry ? 4'd0 : dig + 4'd1;
          end else begin
            carry = (dig == 4'd0);
            count_d[4*k +: 4] = carry ? DMAX : dig - 4'd1;
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      seg_d[7*k +: 7] = glyph(count_q[4*k +: 4]) ^ SEG_XOR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      seg_q   <= {N_DIGITS{SEG_ZERO}};
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign o_count = count_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;
  assign o_seg   = seg_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// tb/tb_multi_digit_counter.sv - scoreboard bench for multi_digit_counter (BCD and hex instances)
module tb_multi_digit_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, stp, load;
  logic [7:0]  load_val;
  logic [7:0]  cnt_b, cnt_h;
  logic        tick_b, tick_h, wrap_b, wrap_h;
  logic [13:0] seg_b, seg_h;

  int errors = 0;
  int checks = 0;
  int ticks_seen = 0;

  typedef struct {
    logic [7:0]  cnt_b, cnt_h;
    logic        tick, wrap_b, wrap_h;
    logic [13:0] seg_b, seg_h;
  } exp_t;
  exp_t sb_q[$];

  int          m_dec, m_hex, m_presc;
  logic        m_rst_seg;

  always #5 clk = ~clk;

  multi_digit_counter #(.N_DIGITS(2), .TICK_DIV(4), .RADIX_BCD(1), .SEG_ACTIVE_LOW(1)) u_bcd (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(stp), .i_load(load),
    .i_load_val(load_val), .o_count(cnt_b), .o_tick(tick_b), .o_wrap(wrap_b), .o_seg(seg_b)
  );

  multi_digit_counter #(.N_DIGITS(2), .TICK_DIV(4), .RADIX_BCD(0), .SEG_ACTIVE_LOW(1)) u_hex (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(stp), .i_load(load),
    .i_load_val(load_val), .o_count(cnt_h), .o_tick(tick_h), .o_wrap(wrap_h), .o_seg(seg_h)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[d];
  endfunction

  function automatic logic [13:0] seg_of(input int hi, input int lo);
    return ~{glyph(hi), glyph(lo)};
  endfunction

  function automatic logic [7:0] dec2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One clock: model the edge from the inputs as driven, push, then compare 1 ns later.
  task automatic clk_cycle();
    exp_t e;
    exp_t o;
    bit   expire, step;
    int   hi, lo;
    @(posedge clk);
    expire = en && (m_presc == 3);
    step   = expire || stp;
    e.seg_b = m_rst_seg ? 14'h2040 : seg_of(m_dec / 10, m_dec % 10);
    e.seg_h = m_rst_seg ? 14'h2040 : seg_of(m_hex / 16, m_hex % 16);
    e.wrap_b = 1'b0;
    e.wrap_h = 1'b0;
    e.tick   = expire;
    m_rst_seg = 1'b0;
    if (rst) begin
      m_dec = 0; m_hex = 0; m_presc = 0; e.tick = 1'b0;
      e.seg_b = 14'h2040; e.seg_h = 14'h2040;
    end else if (load) begin
      hi = (load_val[7:4] > 9) ? 9 : int'(load_val[7:4]);
      lo = (load_val[3:0] > 9) ? 9 : int'(load_val[3:0]);
      m_dec = hi * 10 + lo;
      m_hex = int'(load_val);
      m_presc = 0;
    end else begin
      if (step) begin
        if (up) begin
          e.wrap_b = (m_dec == 99); e.wrap_h = (m_hex == 255);
          m_dec = (m_dec + 1) % 100; m_hex = (m_hex + 1) % 256;
        end else begin
          e.wrap_b = (m_dec == 0); e.wrap_h = (m_hex == 0);
          m_dec = (m_dec + 99) % 100; m_hex = (m_hex + 255) % 256;
        end
      end
      if (en) m_presc = expire ? 0 : m_presc + 1;
    end
    e.cnt_b = dec2bcd(m_dec);
    e.cnt_h = 8'(m_hex);
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check("cnt_bcd", 32'(cnt_b), 32'(o.cnt_b));
    check("cnt_hex", 32'(cnt_h), 32'(o.cnt_h));
    check("tick_bcd", 32'(tick_b), 32'(o.tick));
    check("tick_hex", 32'(tick_h), 32'(o.tick));
    check("wrap_bcd", 32'(wrap_b), 32'(o.wrap_b));
    check("wrap_hex", 32'(wrap_h), 32'(o.wrap_h));
    check("seg_bcd", 32'(seg_b), 32'(o.seg_b));
    check("seg_hex", 32'(seg_h), 32'(o.seg_h));
    if (tick_b) ticks_seen++;
  endtask

  task automatic do_load(input logic [7:0] v, input bit with_step);
    load = 1'b1; load_val = v; stp = with_step;
    clk_cycle();
    load = 1'b0; stp = 1'b0;
  endtask

  task automatic do_step();
    stp = 1'b1;
    clk_cycle();
    stp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; stp = 1'b0; load = 1'b0; load_val = 8'h00;
    m_dec = 0; m_hex = 0; m_presc = 0; m_rst_seg = 1'b1;
    #2;
    repeat (2) clk_cycle();
    check("rst_count", 32'(cnt_b), 32'h00);
    check("rst_seg", 32'(seg_b), 32'h2040);
    check("rst_tick_wrap", 32'({tick_b, wrap_b}), 32'h0);

    rst = 1'b0; en = 1'b1; up = 1'b1;
    ticks_seen = 0;
    repeat (16) clk_cycle();
    check("prescale_ticks", 32'(ticks_seen), 32'd4);
    check("prescale_count", 32'(cnt_b), 32'h04);
    en = 1'b0;

    do_load(8'h98, 1'b0);
    do_step();
    check("bcd_99", 32'(cnt_b), 32'h99);
    check("bcd_99_nowrap", 32'(wrap_b), 32'h0);
    do_step();
    check("bcd_wrap_00", 32'(cnt_b), 32'h00);
    check("bcd_wrap_flag", 32'(wrap_b), 32'h1);
    clk_cycle();
    check("wrap_one_cycle", 32'(wrap_b), 32'h0);

    do_load(8'h00, 1'b0);
    up = 1'b0;
    do_step();
    check("hex_down_ff", 32'(cnt_h), 32'hFF);
    check("hex_down_wrap", 32'(wrap_h), 32'h1);
    check("bcd_down_99", 32'(cnt_b), 32'h99);
    clk_cycle();
    check("hex_seg_ff", 32'(seg_h), 32'(seg_of(15, 15)));

    up = 1'b1;
    do_load(8'hAB, 1'b1);
    check("clamp_99", 32'(cnt_b), 32'h99);
    check("load_no_step_hex", 32'(cnt_h), 32'hAB);
    check("load_no_wrap", 32'(wrap_b), 32'h0);

    do_load(8'h00, 1'b0);
    en = 1'b1;
    repeat (3) clk_cycle();
    do_step();
    check("step_tick_single", 32'(cnt_b), 32'h01);
    check("step_tick_pulse", 32'(tick_b), 32'h1);

    en = 1'b0;
    ticks_seen = 0;
    repeat (10) clk_cycle();
    check("pause_no_tick", 32'(ticks_seen), 32'd0);
    do_step();
    check("pause_step", 32'(cnt_b), 32'h02);

    do_load(8'h57, 1'b0);
    clk_cycle();
    check("seg_57", 32'(seg_b), 32'h0978);
    en = 1'b1; rst = 1'b1; m_rst_seg = 1'b0;
    do_step();
    check("rst_mid_count", 32'(cnt_b), 32'h00);
    rst = 1'b0; en = 1'b0;
    clk_cycle();
    check("rst_mid_seg", 32'(seg_b), 32'h2040);

    // Randomised tail exercises mixed direction, load and step against the model.
    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 1)); up = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 3) == 0); load = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      if (rst) m_rst_seg = 1'b0;
      clk_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
